// File: rtl/param_fifo_buffer.sv
// Synchronous single-clock FIFO with a registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_fifo_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && (count != '0);
    assign wr_acc = wr_en && ((count != FULL_CNT) || rd_acc);

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // NOTE: storage is deliberately left out of reset; zeroed pointers and count
    // already make every stale entry unreachable, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments let a full-FIFO read see the old slot
    // contents while the simultaneous write lands in that same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            // A new error in the same cycle as clr_err wins over the clear.
            overflow  <= (wr_en && !wr_acc) || (overflow  && !clr_err);
            underflow <= (rd_en && !rd_acc) || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Self-checking bench for param_fifo_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_param_fifo_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF_TH  = DEPTH - 2;
    localparam int AE_TH  = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    param_fifo_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of stored words plus expected registered outputs.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ovf;
    logic              m_unf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},     64'(count),        64'(n));
        check({tag, ".full"},      64'(full),         64'(n == DEPTH));
        check({tag, ".empty"},     64'(empty),        64'(n == 0));
        check({tag, ".afull"},     64'(almost_full),  64'(n >= AF_TH));
        check({tag, ".aempty"},    64'(almost_empty), 64'(n <= AE_TH));
        check({tag, ".rd_valid"},  64'(rd_valid),     64'(m_valid));
        check({tag, ".rd_data"},   64'(rd_data),      64'(m_data));
        check({tag, ".overflow"},  64'(overflow),     64'(m_ovf));
        check({tag, ".underflow"}, 64'(underflow),    64'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock cycle: apply inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input string tag, input logic w, input logic [DATA_W-1:0] wd,
                         input logic r, input logic clr);
        logic rd_ok;
        logic wr_ok;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        clr_err = clr;
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_data = q.pop_front();
        if (wr_ok) q.push_back(wd);
        m_valid = rd_ok;
        m_ovf   = (w && !wr_ok) || (m_ovf && !clr);
        m_unf   = (r && !rd_ok) || (m_unf && !clr);
        @(posedge clk);
        #1;
        check_all(tag);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 reset = 1'b0;

        // Basic write-then-read ordering.
        cycle("w11", 1, 32'h11, 0, 0);
        cycle("w22", 1, 32'h22, 0, 0);
        cycle("w33", 1, 32'h33, 0, 0);
        for (int i = 0; i < 3; i++) cycle("rd3", 0, '0, 1, 0);
        cycle("idle", 0, '0, 0, 0);

        // Fill to full, overflow, then clear the sticky flag.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 32'hA0 + 32'(i), 0, 0);
        cycle("ovf", 1, 32'hDEAD, 0, 0);
        cycle("clr", 0, '0, 0, 1);

        // Full with simultaneous read and write; then drain.
        cycle("fullrw", 1, 32'hAA, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, '0, 1, 0);

        // Empty with simultaneous read and write; clear overlapping a new error.
        cycle("emptyrw", 1, 32'h55, 1, 0);
        cycle("rd55", 0, '0, 1, 0);
        cycle("clrset", 0, '0, 1, 1);
        cycle("clr2", 0, '0, 0, 1);

        // 20 interleaved writes and reads wrap the pointers more than twice.
        for (int i = 0; i < 20; i++) cycle("wrap", 1, 32'h100 + 32'(i), i > 1, 0);
        for (int i = 0; i < 4; i++) cycle("wrapd", 0, '0, 1, 0);

        // Asynchronous reset between edges, mid-occupancy.
        for (int i = 0; i < 5; i++) cycle("pre", 1, 32'h200 + 32'(i), 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 reset = 1'b0;
        cycle("rst_rd", 0, '0, 1, 0);
        cycle("rst_clr", 0, '0, 0, 1);

        // Randomized traffic with phases biased toward full, empty and balanced.
        for (int p = 0; p < 40; p++) begin
            int wp;
            int rp;
            case (p % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 50; rp = 50; end
            endcase
            for (int k = 0; k < 50; k++) begin
                cycle("rand", ($urandom_range(99) < wp), $urandom, ($urandom_range(99) < rp),
                      ($urandom_range(99) < 5));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
